// File: rtl/vscale_tohost_mailbox_pkg.sv
// Shared mailbox constants: default tohost/fromhost word addresses and the test verdict encoding.
// The verdict follows the riscv-tests convention: 1 means pass, and any other value carries a fail code in bits [31:1].
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

package vscale_tohost_mailbox_pkg;

    localparam logic [31:0] TOHOST_ADDR_DFLT   = 32'h0000_1000;
    localparam logic [31:0] FROMHOST_ADDR_DFLT = 32'h0000_1004;
    localparam logic [31:0] VERDICT_PASS       = 32'd1;

    typedef struct packed {
        logic        pass;
        logic [30:0] code;
    } verdict_t;

    function automatic verdict_t encode_verdict(input logic [31:0] value);
        verdict_t v;
        v.pass = (value == VERDICT_PASS);
        v.code = v.pass ? 31'd0 : value[31:1];
        return v;
    endfunction

endpackage

// File: rtl/vscale_sync_fifo.sv
// Synchronous FIFO with a count register and wrap-around pointers, no bypass path.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module vscale_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vscale_tohost_mailbox.sv
// Decodes core stores and loads on tohost/fromhost, queues nonzero tohost writes as an HTIF PCR response stream, and latches the first verdict.
// Latency: a store at cycle N is at the queue head and in the verdict outputs at N+1; load data is registered and returned at N+1.
// Backpressure: valid/ready on the response stream; a push into a full queue with no pop is dropped and sets overflow.
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

module vscale_tohost_mailbox
    import vscale_tohost_mailbox_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DFLT,
    parameter logic [31:0] FROMHOST_ADDR = FROMHOST_ADDR_DFLT,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dmem_write,
    input  logic                       dmem_read,
    input  logic [31:0]                dmem_addr,
    input  logic [31:0]                dmem_wdata,
    output logic [31:0]                dmem_rdata,
    output logic                       dmem_rdata_hit,
    input  logic                       fromhost_valid,
    input  logic [31:0]                fromhost_data,
    output logic                       htif_pcr_resp_valid,
    input  logic                       htif_pcr_resp_ready,
    output logic [`HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
    output logic                       overflow,
    output logic                       test_done,
    output logic                       test_pass,
    output logic [30:0]                test_code,
    output logic [63:0]                done_cycles
);

    logic        tohost_hit;
    logic        fromhost_hit;
    logic        tohost_wr;
    logic        fromhost_wr;
    logic        push_vld;
    logic        pop_vld;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] head_dat;
    logic [31:0] tohost_q;
    logic [31:0] fromhost_q;
    logic [63:0] cycle_cnt;
    verdict_t    verdict;

    assign tohost_hit   = (dmem_addr == TOHOST_ADDR);
    assign fromhost_hit = (dmem_addr == FROMHOST_ADDR);
    assign tohost_wr    = dmem_write & tohost_hit;
    assign fromhost_wr  = dmem_write & fromhost_hit;
    assign push_vld     = tohost_wr & (dmem_wdata != 32'd0);
    assign verdict      = encode_verdict(dmem_wdata);

    assign htif_pcr_resp_valid = ~fifo_empty;
    assign pop_vld             = htif_pcr_resp_valid & htif_pcr_resp_ready;
    // Storage is not reset, so the data bus is forced to zero while nothing is queued.
    assign htif_pcr_resp_data  = fifo_empty ? '0 : `HTIF_PCR_WIDTH'(head_dat);

    vscale_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tohost_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_vld),
        .push_data (dmem_wdata),
        .pop       (pop_vld),
        .pop_data  (head_dat),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt      <= '0;
            tohost_q       <= '0;
            fromhost_q     <= '0;
            dmem_rdata     <= '0;
            dmem_rdata_hit <= 1'b0;
            overflow       <= 1'b0;
            test_done      <= 1'b0;
            test_pass      <= 1'b0;
            test_code      <= '0;
            done_cycles    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;

            if (tohost_wr)
                tohost_q <= dmem_wdata;
            // The host write wins over a core clear-to-acknowledge in the same cycle.
            if (fromhost_valid)
                fromhost_q <= fromhost_data;
            else if (fromhost_wr)
                fromhost_q <= dmem_wdata;

            dmem_rdata_hit <= dmem_read & (tohost_hit | fromhost_hit);
            if (dmem_read & tohost_hit)
                dmem_rdata <= tohost_q;
            else if (dmem_read & fromhost_hit)
                dmem_rdata <= fromhost_q;
            else
                dmem_rdata <= '0;

            if (push_vld & fifo_full & ~pop_vld)
                overflow <= 1'b1;

            // The verdict is taken even when the queue drops the write.
            if (push_vld & ~test_done) begin
                test_done   <= 1'b1;
                test_pass   <= verdict.pass;
                test_code   <= verdict.code;
                done_cycles <= cycle_cnt;
            end
        end
    end

endmodule
